mesh_arb_switch: RTL and testbench
==================================

# mesh_arb_switch

Parametrised N-input, M-output registered crossbar for the MESH router datapath, with per-output round-robin allocation and per-output backpressure. Each input presents a valid flag, a packet and a one-hot output request. Each output grants at most one requester per cycle and loads the winning packet into its output register. It replaces the purely combinational select-driven crossbar: allocation, output registering and flow control now live in one block.

## Interface
Parameters:
- N, 5, number of input ports
- M, 5, number of output ports
- DATA_W, 64, packet width in bits

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- i_data[0:N-1]  input  DATA_W each  packet offered by input n
- i_data_val[0:N-1]  input  1 each  input n offers a packet this cycle
- i_output_req[0:N-1]  input  [0:M-1] each  one-hot; element m set means output m is requested
- o_grant[0:N-1]  output  1 each  combinational; input n's packet is taken at this edge
- i_en[0:M-1]  input  1 each  downstream of output m accepts o_data[m] this cycle
- o_data[0:M-1]  output  DATA_W each  registered packet at output m
- o_data_val[0:M-1]  output  1 each  o_data[m] holds a valid packet

## Operation
- Valid request: i_data_val[n]=1 and i_output_req[n] exactly one-hot. Zero-hot or multi-hot requests are ignored: no grant, no state change.
- Output m can load when !o_data_val[m] || i_en[m].
- When output m can load and has at least one valid requester, it grants exactly one requester: the first index found scanning from ptr[m] upward, wrapping N-1 -> 0.
- ptr[m] is a per-output round-robin pointer of width $clog2(N), minimum 1. On a grant to input j, ptr[m] <= (j==N-1) ? 0 : j+1. With no grant, ptr[m] holds.
- o_grant[n]=1 iff some output granted input n. An input requests only one output, so it receives at most one grant.
- Output register per m, at each edge:
  - grant issued: o_data[m] <= winner's i_data, o_data_val[m] <= 1
  - else if i_en[m]: o_data_val[m] <= 0, o_data[m] holds its value
  - else: hold
- Simultaneous drain and load on output m (o_data_val=1, i_en=1, grant): the new packet replaces the old one with no bubble. Sustained throughput is 1 packet/cycle/output.
- i_en[m] while o_data_val[m]=0 has no effect.
- A non-granted input must hold its request. The block stores nothing for inputs.

## Timing
- Reset values, applied asynchronously on reset_n low: o_data_val=0, o_data=0, every ptr=0.
- o_grant is forced to 0 while reset_n=0.
- Reset asserted mid-operation: in-flight output packets are discarded and pointers return to 0. Outputs are valid again no earlier than the first edge after reset_n rises.
- Latency: a packet granted at edge k appears at o_data[m] with o_data_val=1 immediately after edge k (1 cycle).
- o_grant is a function of current inputs, ptr, o_data_val and i_en, settling in the same cycle. There is no register from grant to input pop.
- Combinational paths: i_data_val / i_output_req / i_en -> o_grant. There is no combinational path from any input to o_data or o_data_val.
- Fairness: with all N inputs continuously requesting output m and i_en[m]=1, each input is granted once every N cycles.

## Test plan
- Reset and single transfer, N=M=5: input 2 requests output 4 with data 0xA5, i_en all 1 -> o_grant[2]=1 in that cycle; next cycle o_data[4]=0xA5, o_data_val[4]=1. Earlier, with reset_n=0 mid-stream, all o_data_val=0 and o_grant=0.
- Round-robin fairness: inputs 0, 1 and 3 all request output 0 continuously, i_en[0]=1 -> grants 0, 1, 3, 0, 1, 3; ptr[0] wraps correctly. After a grant to input 4 (N-1), the pointer wraps to 0.
- Backpressure: output 1 valid, i_en[1]=0, input 0 requesting output 1 -> o_grant[0]=0 and o_data[1] held for 3 cycles. Raising i_en[1] -> grant the same cycle, new packet the next cycle, no bubble.
- Parallel non-conflicting traffic: input n requests output (n+1)%5 for all n -> all five grants in the same cycle; all outputs valid the next cycle with the correct permuted data.
- Malformed requests: i_output_req = 0b01100 or 0b00000 with valid=1 -> no grant, output state and ptr unchanged. Valid=0 with a one-hot request -> no grant.
- Drain without load: o_data_val[3]=1, i_en[3]=1, no requesters -> o_data_val[3]=0 the next cycle and o_data[3] unchanged.

Source files
------------

// File: rtl/mesh_arb_switch.sv
// N-input, M-output registered crossbar with per-output round-robin allocation
// and per-output backpressure; the grant goes back to the inputs in the same cycle.
module mesh_arb_switch #(
  parameter int unsigned N      = 5,
  parameter int unsigned M      = 5,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] i_data       [N],
  input  logic              i_data_val   [N],
  input  logic [0:M-1]      i_output_req [N],
  output logic              o_grant      [N],
  input  logic              i_en         [M],
  output logic [DATA_W-1:0] o_data       [M],
  output logic              o_data_val   [M]
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] win_all [M];

  for (genvar m = 0; m < int'(M); m++) begin : g_out
    logic [N-1:0]       req_c;
    logic [N-1:0]       win_c;
    logic               found_c;
    logic               can_load_c;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt_c;
    logic [DATA_W-1:0]  win_data_c;

    // Only well-formed (valid, exactly one-hot) requests targeting this output compete.
    always_comb begin
      req_c = '0;
      for (int j = 0; j < int'(N); j++) begin
        req_c[j] = i_data_val[j] && $onehot(i_output_req[j]) && i_output_req[j][m];
      end
    end

    // Round-robin pick: scan indices >= ptr first, then wrap to those below ptr.
    always_comb begin
      can_load_c = !o_data_val[m] || i_en[m];
      win_c      = '0;
      found_c    = 1'b0;
      ptr_nxt_c  = ptr;
      win_data_c = '0;
      if (can_load_c) begin
        for (int j = 0; j < int'(N); j++) begin
          if (!found_c && req_c[j] && (PTR_W'(j) >= ptr)) begin
            win_c[j]  = 1'b1;
            found_c   = 1'b1;
            ptr_nxt_c = (j == int'(N) - 1) ? '0 : PTR_W'(j + 1);
          end
        end
        for (int j = 0; j < int'(N); j++) begin
          if (!found_c && req_c[j] && (PTR_W'(j) < ptr)) begin
            win_c[j]  = 1'b1;
            found_c   = 1'b1;
            ptr_nxt_c = (j == int'(N) - 1) ? '0 : PTR_W'(j + 1);
          end
        end
      end
      for (int j = 0; j < int'(N); j++) begin
        win_data_c = win_data_c | (i_data[j] & {DATA_W{win_c[j]}});
      end
    end

    assign win_all[m] = win_c;

    // Load on grant (a simultaneous drain is replaced without a bubble), else drain.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        o_data[m]     <= '0;
        o_data_val[m] <= 1'b0;
        ptr           <= '0;
      end else if (found_c) begin
        o_data[m]     <= win_data_c;
        o_data_val[m] <= 1'b1;
        ptr           <= ptr_nxt_c;
      end else if (i_en[m]) begin
        o_data_val[m] <= 1'b0;
      end
    end
  end

  // An input requests a single output, so OR-ing over outputs yields at most one grant.
  always_comb begin
    logic g;
    g = 1'b0;
    for (int n = 0; n < int'(N); n++) begin
      g = 1'b0;
      for (int m = 0; m < int'(M); m++) begin
        g = g | win_all[m][n];
      end
      o_grant[n] = g && reset_n;
    end
  end

endmodule

// File: tb/tb_mesh_arb_switch.sv
// Self-checking bench for mesh_arb_switch: directed scenarios plus randomized
// traffic compared against a scan-from-pointer reference model.
module tb_mesh_arb_switch;
  localparam int unsigned N  = 5;
  localparam int unsigned M  = 5;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] i_data       [N];
  logic          i_data_val   [N];
  logic [0:M-1]  i_output_req [N];
  logic          o_grant      [N];
  logic          i_en         [M];
  logic [DW-1:0] o_data       [M];
  logic          o_data_val   [M];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] m_data [M];
  logic          m_val  [M];
  int            m_ptr  [M];
  int            e_win  [M];
  logic          e_grant[N];

  mesh_arb_switch #(.N(N), .M(M), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_data_val(i_data_val),
    .i_output_req(i_output_req), .o_grant(o_grant), .i_en(i_en),
    .o_data(o_data), .o_data_val(o_data_val)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int m = 0; m < int'(M); m++) begin
      m_data[m] = '0;
      m_val[m]  = 1'b0;
      m_ptr[m]  = 0;
    end
  endfunction

  // Each free output takes the first well-formed requester at or after its pointer, mod N.
  function automatic void model_eval();
    for (int n = 0; n < int'(N); n++) e_grant[n] = 1'b0;
    for (int m = 0; m < int'(M); m++) begin
      e_win[m] = -1;
      if (reset_n && (!m_val[m] || i_en[m])) begin
        for (int k = 0; k < int'(N); k++) begin
          int j;
          j = (m_ptr[m] + k) % int'(N);
          if (e_win[m] < 0 && i_data_val[j] && $countones(i_output_req[j]) == 1 &&
              i_output_req[j][m]) begin
            e_win[m]   = j;
            e_grant[j] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (!reset_n) model_reset();
    else begin
      for (int m = 0; m < int'(M); m++) begin
        if (e_win[m] >= 0) begin
          m_data[m] = i_data[e_win[m]];
          m_val[m]  = 1'b1;
          m_ptr[m]  = (e_win[m] + 1) % int'(N);
        end else if (i_en[m]) begin
          m_val[m] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    for (int n = 0; n < int'(N); n++) begin
      i_data[n] = '0;
      i_data_val[n] = 1'b0;
      i_output_req[n] = '0;
    end
  endtask

  task automatic request(input int n, input int m, input logic [DW-1:0] d);
    i_data[n] = d;
    i_data_val[n] = 1'b1;
    i_output_req[n] = '0;
    i_output_req[n][m] = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    for (int m = 0; m < int'(M); m++) i_en[m] = 1'b1;
    request(0, 1, 64'h11);
    request(3, 2, 64'h33);
    model_reset();
    #3;
    for (int n = 0; n < int'(N); n++) begin
      checks++;
      if (o_grant[n] !== 1'b0) begin
        errors++;
        $display("FAIL reset_grant[%0d]: got %b exp 0", n, o_grant[n]);
      end
    end
    for (int m = 0; m < int'(M); m++) begin
      checks++;
      if (o_data_val[m] !== 1'b0 || o_data[m] !== '0) begin
        errors++;
        $display("FAIL reset_out[%0d]: got val=%b data=%h exp val=0 data=0", m, o_data_val[m], o_data[m]);
      end
    end
    tick();
    tick();
    clear_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    clear_inputs();
    for (int m = 0; m < int'(M); m++) i_en[m] = 1'b1;
    request(2, 4, 64'hA5);
    #1;
    model_eval();
    for (int n = 0; n < int'(N); n++) begin
      checks++;
      if (o_grant[n] !== ((n == 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL single_grant[%0d]: got %b exp %b", n, o_grant[n], n == 2);
      end
    end
    tick();
    checks++;
    if (o_data_val[4] !== 1'b1 || o_data[4] !== 64'hA5) begin
      errors++;
      $display("FAIL single_out4: got val=%b data=%h exp val=1 data=a5", o_data_val[4], o_data[4]);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_fairness();
    int order [8] = '{0, 1, 3, 0, 1, 3, 4, 0};
    clear_inputs();
    for (int m = 0; m < int'(M); m++) i_en[m] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      if (c < 6) begin
        request(0, 0, {32'hF0, 32'(c)});
        request(1, 0, {32'hF1, 32'(c)});
        request(3, 0, {32'hF3, 32'(c)});
      end else begin
        request(0, 0, {32'hF0, 32'(c)});
        request(4, 0, {32'hF4, 32'(c)});
      end
      #1;
      model_eval();
      for (int n = 0; n < int'(N); n++) begin
        checks++;
        if (o_grant[n] !== ((n == order[c]) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL rr_grant c%0d in%0d: got %b exp %b", c, n, o_grant[n], n == order[c]);
        end
      end
      tick();
      checks++;
      if (o_data_val[0] !== 1'b1 || o_data[0] !== i_data[order[c]]) begin
        errors++;
        $display("FAIL rr_out0 c%0d: got %h exp %h", c, o_data[0], i_data[order[c]]);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    clear_inputs();
    for (int m = 0; m < int'(M); m++) i_en[m] = 1'b1;
    request(2, 1, 64'hB0B0);
    tick();
    clear_inputs();
    i_en[1] = 1'b0;
    request(0, 1, 64'hC1C1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (o_grant[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_grant c%0d: got %b exp 0", c, o_grant[0]);
      end
      tick();
      checks++;
      if (o_data_val[1] !== 1'b1 || o_data[1] !== 64'hB0B0) begin
        errors++;
        $display("FAIL bp_hold c%0d: got val=%b data=%h exp val=1 data=b0b0", c, o_data_val[1], o_data[1]);
      end
    end
    i_en[1] = 1'b1;
    #1;
    checks++;
    if (o_grant[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_grant: got %b exp 1", o_grant[0]);
    end
    tick();
    checks++;
    if (o_data_val[1] !== 1'b1 || o_data[1] !== 64'hC1C1) begin
      errors++;
      $display("FAIL bp_release_out: got val=%b data=%h exp val=1 data=c1c1", o_data_val[1], o_data[1]);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_parallel();
    logic [DW-1:0] d [N];
    clear_inputs();
    for (int m = 0; m < int'(M); m++) i_en[m] = 1'b1;
    for (int n = 0; n < int'(N); n++) begin
      d[n] = {$urandom, $urandom};
      request(n, (n + 1) % int'(M), d[n]);
    end
    #1;
    model_eval();
    for (int n = 0; n < int'(N); n++) begin
      checks++;
      if (o_grant[n] !== 1'b1) begin
        errors++;
        $display("FAIL par_grant[%0d]: got %b exp 1", n, o_grant[n]);
      end
    end
    tick();
    for (int n = 0; n < int'(N); n++) begin
      checks++;
      if (o_data_val[(n + 1) % int'(M)] !== 1'b1 || o_data[(n + 1) % int'(M)] !== d[n]) begin
        errors++;
        $display("FAIL par_out[%0d]: got %h exp %h", (n + 1) % int'(M), o_data[(n + 1) % int'(M)], d[n]);
      end
    end
  endtask

  task automatic test_malformed();
    clear_inputs();
    for (int m = 0; m < int'(M); m++) i_en[m] = 1'b0;
    i_data_val[0] = 1'b1; i_data[0] = 64'hDEAD;
    i_output_req[0][1] = 1'b1; i_output_req[0][2] = 1'b1;
    i_data_val[1] = 1'b1; i_data[1] = 64'hBEEF;
    request(2, 0, 64'hCAFE);
    i_data_val[2] = 1'b0;
    for (int m = 0; m < int'(M); m++) i_en[m] = (m == 0) ? 1'b1 : 1'b0;
    #1;
    model_eval();
    for (int n = 0; n < int'(N); n++) begin
      checks++;
      if (o_grant[n] !== 1'b0) begin
        errors++;
        $display("FAIL malformed_grant[%0d]: got %b exp 0", n, o_grant[n]);
      end
    end
    tick();
    for (int m = 0; m < int'(M); m++) begin
      checks++;
      if (o_data_val[m] !== m_val[m] || o_data[m] !== m_data[m]) begin
        errors++;
        $display("FAIL malformed_out[%0d]: got val=%b data=%h exp val=%b data=%h", m, o_data_val[m], o_data[m], m_val[m], m_data[m]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_drain();
    clear_inputs();
    for (int m = 0; m < int'(M); m++) i_en[m] = 1'b1;
    request(2, 3, 64'h3333);
    tick();
    clear_inputs();
    #1;
    for (int n = 0; n < int'(N); n++) begin
      checks++;
      if (o_grant[n] !== 1'b0) begin
        errors++;
        $display("FAIL drain_grant[%0d]: got %b exp 0", n, o_grant[n]);
      end
    end
    tick();
    checks++;
    if (o_data_val[3] !== 1'b0 || o_data[3] !== 64'h3333) begin
      errors++;
      $display("FAIL drain_out3: got val=%b data=%h exp val=0 data=3333", o_data_val[3], o_data[3]);
    end
  endtask

  task automatic random_inputs();
    for (int n = 0; n < int'(N); n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      i_data[n] = {$urandom, $urandom};
      i_data_val[n] = ($urandom_range(0, 3) != 0);
      if (r == 0) i_output_req[n] = '0;
      else if (r == 1) i_output_req[n] = M'($urandom);
      else begin
        i_output_req[n] = '0;
        i_output_req[n][$urandom_range(0, M - 1)] = 1'b1;
      end
    end
    for (int m = 0; m < int'(M); m++) i_en[m] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      random_inputs();
      #1;
      model_eval();
      for (int n = 0; n < int'(N); n++) begin
        checks++;
        if (o_grant[n] !== e_grant[n]) begin
          errors++;
          $display("FAIL rand_grant c%0d in%0d: got %b exp %b", c, n, o_grant[n], e_grant[n]);
        end
      end
      tick();
      for (int m = 0; m < int'(M); m++) begin
        checks++;
        if (o_data_val[m] !== m_val[m] || (m_val[m] && o_data[m] !== m_data[m])) begin
          errors++;
          $display("FAIL rand_out c%0d out%0d: got val=%b data=%h exp val=%b data=%h", c, m, o_data_val[m], o_data[m], m_val[m], m_data[m]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int m = 0; m < int'(M); m++) i_en[m] = 1'b0;
    clear_inputs();
    for (int n = 0; n < int'(N); n++) request(n, n, {32'hAB, 32'(n)});
    tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < int'(M); m++) begin
      checks++;
      if (o_data_val[m] !== 1'b0 || o_data[m] !== '0) begin
        errors++;
        $display("FAIL midreset_out[%0d]: got val=%b data=%h exp val=0 data=0", m, o_data_val[m], o_data[m]);
      end
    end
    for (int n = 0; n < int'(N); n++) begin
      checks++;
      if (o_grant[n] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_grant[%0d]: got %b exp 0", n, o_grant[n]);
      end
    end
    tick();
    reset_n = 1'b1;
    clear_inputs();
    request(1, 0, 64'h77);
    request(4, 0, 64'h44);
    #1;
    model_eval();
    for (int n = 0; n < int'(N); n++) begin
      checks++;
      if (o_grant[n] !== e_grant[n] || o_grant[n] !== ((n == 1) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL postreset_grant[%0d]: got %b exp %b", n, o_grant[n], n == 1);
      end
    end
    tick();
    checks++;
    if (o_data_val[0] !== 1'b1 || o_data[0] !== 64'h77 || m_data[0] !== 64'h77) begin
      errors++;
      $display("FAIL postreset_out0: got val=%b data=%h exp val=1 data=77", o_data_val[0], o_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_parallel();
    test_malformed();
    test_drain();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
